// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared types and limits for the bit-serial adder slice.
//   state_t   : controller state encoding (IDLE, SHIFT, DONE)
//   MAX_WIDTH : largest supported operand width
package serial_add_pkg;

  localparam int unsigned MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// full_adder: single-bit full adder cell, time-multiplexed by serial_add_ctrl.
//   a, b, cin : addend bits and carry-in
//   sum, cout : sum bit and carry-out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer. Adds two WIDTH-bit operands
// LSB first through one full_adder over WIDTH cycles.
//   clk, rst             : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (a_i, b_i, cin_i)
//   out_valid / out_ready: result handshake (sum_o, cout_o, ovf_o)
//   busy_o               : high while bits are being shifted through the adder
// Optional: define SERIAL_ADD_SUB_EN to add sub_i; when high at acceptance
// the result is a_i - b_i (cout_o=1 means no borrow).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub_i,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             busy_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("serial_add_ctrl: WIDTH out of range 1..64");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cmsb_q, cmsb_d;   // carry into the MSB, kept for overflow
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic fa_sum;
  logic fa_cout;

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d   = a_i;
`ifdef SERIAL_ADD_SUB_EN
          // A - B computed as A + ~B + 1
          b_d     = sub_i ? ~b_i : b_i;
          carry_d = sub_i ? 1'b1 : cin_i;
`else
          b_d     = b_i;
          carry_d = cin_i;
`endif
          cnt_d   = '0;
          sum_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = fa_sum;
        a_d              = a_q >> 1;
        b_d              = b_q >> 1;
        carry_d          = fa_cout;
        cnt_d            = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cmsb_d  = carry_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Handshake/status outputs registered alongside the state they decode.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == SHIFT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cmsb_q      <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cmsb_q      <= cmsb_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy_o    = busy_q;
  assign sum_o     = sum_q;
  assign cout_o    = carry_q;
  assign ovf_o     = cmsb_q ^ carry_q;

endmodule
